// File: rtl/pc_unit.sv
// Program-counter stage: selects and registers the next PC, traps misaligned targets, HALT/resume, counters.
// Latency: every PC/state/counter update is visible one cycle after the rising edge; pc_plus4 is combinational.
// Backpressure: stall freezes PC, state, epc and counters in RUN; in HALT only resume (or reset) has any effect.
module pc_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] TRAP_VEC = 32'h0000_0100,
    parameter int          CNT_W    = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             stall,
    input  logic             branch,
    input  logic             BranchTaken,
    input  logic             jal,
    input  logic             jalr,
    input  logic [31:0]      imm,
    input  logic [31:0]      rs1,
    input  logic             halt_req,
    input  logic             resume,
    output logic [31:0]      pc,
    output logic [31:0]      pc_plus4,
    output logic             halted,
    output logic             misalign_trap,
    output logic [31:0]      epc,
    output logic [CNT_W-1:0] retire_cnt,
    output logic [CNT_W-1:0] taken_cnt
);

    typedef enum logic {
        RUN  = 1'b0,
        HALT = 1'b1
    } state_t;

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    state_t      state;
    logic [31:0] jalr_sum;
    logic [31:0] rel_target;
    logic [31:0] target;
    logic        br_taken;
    logic        redir;
    logic        misaligned;

    // Link value and the sequential fall-through target; wraps silently mod 2^32.
    assign pc_plus4 = pc + 32'd4;

    // Next-PC selection, priority jalr > jal > taken branch > sequential.
    always_comb begin
        jalr_sum   = rs1 + imm;
        rel_target = pc + imm;
        br_taken   = branch & BranchTaken;
        redir      = jalr | jal | br_taken;
        target     = pc_plus4;
        if (jalr) begin
            // JALR drops bit 0 of the computed address; bit 1 can still misalign.
            target = jalr_sum & ~32'h1;
        end else if (jal || br_taken) begin
            target = rel_target;
        end
        misaligned = redir & (target[1:0] != 2'b00);
    end

    // RUN/HALT FSM with registered pc, epc, trap pulse, halted flag and counters.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= RUN;
            pc            <= RESET_PC;
            halted        <= 1'b0;
            misalign_trap <= 1'b0;
            epc           <= 32'h0;
            retire_cnt    <= '0;
            taken_cnt     <= '0;
        end else begin
            // The trap flag is a single-cycle pulse; only the trap branch below re-raises it.
            misalign_trap <= 1'b0;
            if (state == RUN) begin
                if (!stall) begin
                    if (misaligned) begin
                        // A trapping instruction does not retire and its transfer is not counted;
                        // a simultaneous halt request is dropped with it.
                        pc            <= TRAP_VEC;
                        epc           <= pc;
                        misalign_trap <= 1'b1;
                    end else if (halt_req) begin
                        // pc stays on the halting instruction so resume can step past it.
                        state      <= HALT;
                        halted     <= 1'b1;
                        retire_cnt <= retire_cnt + CNT_ONE;
                    end else begin
                        pc         <= target;
                        retire_cnt <= retire_cnt + CNT_ONE;
                        if (redir) begin
                            taken_cnt <= taken_cnt + CNT_ONE;
                        end
                    end
                end
            end else begin
                // In HALT everything except resume is ignored, including stall.
                if (resume) begin
                    state  <= RUN;
                    halted <= 1'b0;
                    pc     <= pc_plus4;
                end
            end
        end
    end

endmodule

// File: tb/tb_pc_unit.sv
// Directed bench for pc_unit: reset, sequential flow, branches, JAL/JALR, misaligned trap, stall, HALT and wrap.
// Inputs change 1 time unit after each rising edge; outputs are checked at the same point.
// Expected values are hand-computed constants in each step.
module tb_pc_unit;

    logic        clk;
    logic        rst_n;
    logic        stall;
    logic        branch;
    logic        BranchTaken;
    logic        jal;
    logic        jalr;
    logic [31:0] imm;
    logic [31:0] rs1;
    logic        halt_req;
    logic        resume;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic        halted;
    logic        misalign_trap;
    logic [31:0] epc;
    logic [31:0] retire_cnt;
    logic [31:0] taken_cnt;

    int passed;
    int total;

    pc_unit #(
        .RESET_PC(32'h0000_0000),
        .TRAP_VEC(32'h0000_0100),
        .CNT_W(32)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .stall(stall),
        .branch(branch),
        .BranchTaken(BranchTaken),
        .jal(jal),
        .jalr(jalr),
        .imm(imm),
        .rs1(rs1),
        .halt_req(halt_req),
        .resume(resume),
        .pc(pc),
        .pc_plus4(pc_plus4),
        .halted(halted),
        .misalign_trap(misalign_trap),
        .epc(epc),
        .retire_cnt(retire_cnt),
        .taken_cnt(taken_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        stall       = 1'b0;
        branch      = 1'b0;
        BranchTaken = 1'b0;
        jal         = 1'b0;
        jalr        = 1'b0;
        imm         = 32'h0;
        rs1         = 32'h0;
        halt_req    = 1'b0;
        resume      = 1'b0;
    endtask

    task automatic do_jal(input logic [31:0] off);
        idle();
        jal = 1'b1;
        imm = off;
        tick();
        idle();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        passed = 0;
        total  = 0;
        idle();
        rst_n = 1'b0;

        // 1: reset values, then sequential flow.
        tick();
        tick();
        chk("rst_pc", pc, 32'h0);
        chk("rst_pc_plus4", pc_plus4, 32'h4);
        chk("rst_retire", retire_cnt, 32'd0);
        chk("rst_taken", taken_cnt, 32'd0);
        chk("rst_halted", {31'b0, halted}, 32'd0);
        chk("rst_trap", {31'b0, misalign_trap}, 32'd0);
        chk("rst_epc", epc, 32'h0);
        rst_n = 1'b1;
        chk("rel_pc0", pc, 32'h0);
        tick();
        chk("seq_pc4", pc, 32'h4);
        chk("seq_ret1", retire_cnt, 32'd1);
        tick();
        chk("seq_pc8", pc, 32'h8);
        chk("seq_ret2", retire_cnt, 32'd2);

        // 2: taken and not-taken branch at pc=0x10 with imm=-8.
        do_jal(32'h8);
        chk("jal_pc10", pc, 32'h10);
        chk("jal_taken1", taken_cnt, 32'd1);
        branch = 1'b1; BranchTaken = 1'b1; imm = 32'hFFFF_FFF8;
        tick();
        idle();
        chk("br_t_pc", pc, 32'h08);
        chk("br_t_taken", taken_cnt, 32'd2);
        chk("br_t_ret", retire_cnt, 32'd4);
        do_jal(32'h8);
        branch = 1'b1; BranchTaken = 1'b0; imm = 32'hFFFF_FFF8;
        tick();
        idle();
        chk("br_nt_pc", pc, 32'h14);
        chk("br_nt_taken", taken_cnt, 32'd3);
        chk("br_nt_ret", retire_cnt, 32'd6);

        // 3: misaligned JALR (0x101+2 = 0x103 -> 0x102) traps to 0x100.
        do_jal(32'hFFFF_FFFC);
        chk("jal_back_pc", pc, 32'h10);
        jalr = 1'b1; rs1 = 32'h101; imm = 32'h2;
        tick();
        idle();
        chk("trap_pc", pc, 32'h100);
        chk("trap_epc", epc, 32'h10);
        chk("trap_pulse", {31'b0, misalign_trap}, 32'd1);
        chk("trap_ret", retire_cnt, 32'd7);
        chk("trap_taken", taken_cnt, 32'd4);
        tick();
        chk("trap_pulse_end", {31'b0, misalign_trap}, 32'd0);
        chk("post_trap_pc", pc, 32'h104);
        chk("post_trap_ret", retire_cnt, 32'd8);

        // 4: JALR clears bit 0 only; aligned result, no trap.
        jalr = 1'b1; rs1 = 32'h201; imm = 32'h0;
        tick();
        idle();
        chk("jalr_pc", pc, 32'h200);
        chk("jalr_trap", {31'b0, misalign_trap}, 32'd0);
        chk("jalr_taken", taken_cnt, 32'd5);
        chk("jalr_epc_held", epc, 32'h10);

        // 5: stall three cycles with a pending JAL, then release.
        stall = 1'b1; jal = 1'b1; imm = 32'h40;
        tick();
        tick();
        tick();
        chk("stall_pc", pc, 32'h200);
        chk("stall_ret", retire_cnt, 32'd9);
        chk("stall_taken", taken_cnt, 32'd5);
        stall = 1'b0;
        tick();
        idle();
        chk("unstall_pc", pc, 32'h240);
        chk("unstall_taken", taken_cnt, 32'd6);
        chk("unstall_ret", retire_cnt, 32'd10);

        // 6: HALT at 0x20 ignores control inputs, resume steps to 0x24.
        do_jal(32'hFFFF_FDE0);
        chk("to20_pc", pc, 32'h20);
        halt_req = 1'b1;
        tick();
        idle();
        chk("halt_flag", {31'b0, halted}, 32'd1);
        chk("halt_pc", pc, 32'h20);
        chk("halt_ret", retire_cnt, 32'd12);
        jal = 1'b1; imm = 32'h40; branch = 1'b1; BranchTaken = 1'b1;
        tick();
        tick();
        idle();
        chk("halt_hold_pc", pc, 32'h20);
        chk("halt_hold_flag", {31'b0, halted}, 32'd1);
        chk("halt_hold_ret", retire_cnt, 32'd12);
        chk("halt_hold_taken", taken_cnt, 32'd7);
        resume = 1'b1;
        tick();
        idle();
        chk("resume_pc", pc, 32'h24);
        chk("resume_flag", {31'b0, halted}, 32'd0);
        chk("resume_ret", retire_cnt, 32'd12);

        // Wrap: 0xFFFF_FFFC + 4 = 0.
        do_jal(32'hFFFF_FFD8);
        chk("wrap_pre_pc", pc, 32'hFFFF_FFFC);
        chk("wrap_plus4", pc_plus4, 32'h0);
        tick();
        chk("wrap_pc", pc, 32'h0);
        chk("wrap_ret", retire_cnt, 32'd14);

        // Async reset while halted aborts immediately, without a clock edge.
        halt_req = 1'b1;
        tick();
        idle();
        chk("halt2_flag", {31'b0, halted}, 32'd1);
        rst_n = 1'b0;
        #1;
        chk("arst_halted", {31'b0, halted}, 32'd0);
        chk("arst_pc", pc, 32'h0);
        chk("arst_ret", retire_cnt, 32'd0);
        chk("arst_taken", taken_cnt, 32'd0);
        chk("arst_epc", epc, 32'h0);
        tick();
        rst_n = 1'b1;
        tick();
        chk("arst_run_pc", pc, 32'h4);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
